// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
//   rx_state_t      receiver FSM state encoding
//   UART_DATA_BITS  default data bits per frame
//   UART_OVERSAMPLE default ticks per bit period
//   mid_bit_idx()   tick count at which the middle of a bit is reached
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_t;

    // Counting from the detected falling edge, this tick lands mid start bit.
    function automatic int unsigned mid_bit_idx(input int unsigned oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for a single asynchronous input.
//   clock    system clock
//   reset    asynchronous active-high reset, loads RESET_VAL into both flops
//   i_d      asynchronous input
//   o_q      synchronized output (2 cycles of latency)
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
//   clock         system clock
//   reset         asynchronous active-high reset
//   tick          one-cycle strobe at OVERSAMPLE x baud
//   rx            asynchronous serial line, idle high
//   data          last received word, held until the next frame completes
//   valid         one-cycle pulse when data and flags are updated
//   parity_error  parity mismatch on the last frame (held)
//   frame_error   stop bit sampled low on the last frame (held)
//   busy          high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int unsigned TCW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = $clog2(DATA_BITS) + 1;

    localparam logic [TCW-1:0] TC_MID  = TCW'(mid_bit_idx(OVERSAMPLE));
    localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);
    localparam logic           ODD_BIT = (PARITY_ODD != 0);
    localparam logic           PAR_ON  = (PARITY_EN != 0);

    rx_state_t            r_state;
    logic [TCW-1:0]       r_tick_cnt;
    logic [BCW-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity_bit;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_parity_error;
    logic                 r_frame_error;

    logic w_rx_s;
    logic w_par_err;

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // Nonzero when data plus received parity bit disagree with the selected parity.
    assign w_par_err = PAR_ON ? (^r_shift ^ r_parity_bit ^ ODD_BIT) : 1'b0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= StIdle;
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_parity_bit   <= 1'b0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (tick) begin
                case (r_state)
                    StIdle: begin
                        if (!w_rx_s) begin
                            r_state    <= StStart;
                            r_tick_cnt <= '0;
                        end
                    end
                    StStart: begin
                        if (r_tick_cnt == TC_MID) begin
                            r_tick_cnt <= '0;
                            if (!w_rx_s) begin
                                r_state   <= StData;
                                r_bit_cnt <= '0;
                            end else begin
                                // Glitch shorter than half a bit: not a real start bit.
                                r_state <= StIdle;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TCW'(1);
                        end
                    end
                    StData: begin
                        if (r_tick_cnt == TC_LAST) begin
                            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= r_bit_cnt + BCW'(1);
                            if (r_bit_cnt == BC_LAST) begin
                                r_state <= PAR_ON ? StParity : StStop;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TCW'(1);
                        end
                    end
                    StParity: begin
                        if (r_tick_cnt == TC_LAST) begin
                            r_parity_bit <= w_rx_s;
                            r_tick_cnt   <= '0;
                            r_state      <= StStop;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TCW'(1);
                        end
                    end
                    StStop: begin
                        if (r_tick_cnt == TC_LAST) begin
                            r_data         <= r_shift;
                            r_frame_error  <= !w_rx_s;
                            r_parity_error <= w_par_err;
                            r_valid        <= 1'b1;
                            r_tick_cnt     <= '0;
                            // A low stop bit means the line may be held in break.
                            r_state        <= w_rx_s ? StIdle : StBreak;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TCW'(1);
                        end
                    end
                    StBreak: begin
                        if (w_rx_s) begin
                            r_state <= StIdle;
                        end
                    end
                    default: begin
                        r_state    <= StIdle;
                        r_tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign data         = r_data;
    assign valid        = r_valid;
    assign parity_error = r_parity_error;
    assign frame_error  = r_frame_error;
    assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick = 1'b0;
    logic       rx;
    logic       rx_p;
    logic [7:0] data,  p_data;
    logic       valid, p_valid;
    logic       pe,    p_pe;
    logic       fe,    p_fe;
    logic       busy,  p_busy;

    int n_vec = 0;
    int n_err = 0;
    int vcnt0 = 0;
    int vcnt1 = 0;
    int tick_div = 4;
    int tick_ctr = 0;

    // Expected frames as {parity_error, frame_error, data}.
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    uart_rx dut (
        .clock        (clk),
        .reset        (reset),
        .tick         (tick),
        .rx           (rx),
        .data         (data),
        .valid        (valid),
        .parity_error (pe),
        .frame_error  (fe),
        .busy         (busy)
    );

    uart_rx #(
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut_p (
        .clock        (clk),
        .reset        (reset),
        .tick         (tick),
        .rx           (rx_p),
        .data         (p_data),
        .valid        (p_valid),
        .parity_error (p_pe),
        .frame_error  (p_fe),
        .busy         (p_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick_ctr >= tick_div - 1) begin
            tick_ctr <= 0;
            tick     <= 1'b1;
        end else begin
            tick_ctr <= tick_ctr + 1;
            tick     <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each bit lasts OVERSAMPLE ticks; line changes happen away from the clock edge.
    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx = v; else rx_p = v;
        repeat (16 * tick_div) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic par_en,
                              input logic pbit, input logic stopb);
        logic exp_pe;
        // Even parity: total ones over data plus parity bit must be even.
        exp_pe = par_en ? (($countones({d, pbit}) % 2) == 1) : 1'b0;
        if (which == 0) q0.push_back({exp_pe, ~stopb, d});
        else            q1.push_back({exp_pe, ~stopb, d});
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (par_en) drive_bit(which, pbit);
        drive_bit(which, stopb);
    endtask

    // Compare process: every valid pulse must match the next expected frame.
    initial begin
        logic prev0, prev1;
        prev0 = 1'b0;
        prev1 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev0 = 1'b0;
                prev1 = 1'b0;
            end else begin
                if (valid) begin
                    vcnt0++;
                    check("valid0_single_cycle", 32'(prev0), 32'd0);
                    if (q0.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_valid0: got data 0x%0h, expected no pulse at %0t",
                                 data, $time);
                    end else begin
                        check("frame0", 32'({pe, fe, data}), 32'(q0.pop_front()));
                    end
                end
                if (p_valid) begin
                    vcnt1++;
                    check("valid1_single_cycle", 32'(prev1), 32'd0);
                    if (q1.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_valid1: got data 0x%0h, expected no pulse at %0t",
                                 p_data, $time);
                    end else begin
                        check("frame1", 32'({p_pe, p_fe, p_data}), 32'(q1.pop_front()));
                    end
                end
                prev0 = valid;
                prev1 = p_valid;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int found;
        reset = 1'b1;
        rx    = 1'b1;
        rx_p  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data",  32'(data),  32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_flags", 32'({pe, fe}), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 1: plain 8N1 frame
        v0 = vcnt0;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("t1_data",   32'(data), 32'hA5);
        check("t1_flags",  32'({pe, fe}), 32'h0);
        check("t1_busy",   32'(busy), 32'h0);
        check("t1_pulses", 32'(vcnt0 - v0), 32'd1);

        // 2: short low glitch is rejected at mid start bit
        v0 = vcnt0;
        rx = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (busy) found = 1;
        end
        check("t2_busy_rise", 32'(found), 32'd1);
        if (found != 0) begin
            for (int k = 1; k <= 8; k++) begin
                for (int j = 0; j < 8 && !tick; j++) @(negedge clk);
                @(negedge clk);
                if (k == 2) rx = 1'b1;
                check($sformatf("t2_busy_tick%0d", k), 32'(busy), (k < 8) ? 32'd1 : 32'd0);
            end
        end
        rx = 1'b1;
        repeat (64) @(negedge clk);
        check("t2_data_held", 32'(data), 32'hA5);
        check("t2_no_pulse",  32'(vcnt0 - v0), 32'd0);

        // 3: bad stop bit followed by a long break, then a good frame
        v0 = vcnt0;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (20 * 64) @(negedge clk);
        check("t3_break_busy", 32'(busy), 32'd1);
        check("t3_ferr_frame", 32'({fe, data}), 32'h13C);
        rx = 1'b1;
        repeat (2 * 64) @(negedge clk);
        check("t3_idle_busy", 32'(busy), 32'd0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        check("t3_good_frame", 32'({fe, data}), 32'h055);
        check("t3_pulses",     32'(vcnt0 - v0), 32'd2);

        // 5: reset during data bit 4 aborts the frame
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (64) @(negedge clk);
        end
        rx = 1'b1;
        repeat (32) @(negedge clk);
        check("t5_busy_before", 32'(busy), 32'd1);
        v0 = vcnt0;
        reset = 1'b1;
        #1;
        check("t5_reset_outputs", 32'({data, valid, pe, fe, busy}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4 * 64) @(negedge clk);
        check("t5_no_pulse", 32'(vcnt0 - v0), 32'd0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        check("t5_data",   32'(data), 32'h81);
        check("t5_pulses", 32'(vcnt0 - v0), 32'd1);

        // 4: even parity on the parity-enabled instance
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        check("t4_par_ok",  32'({p_pe, p_fe, p_data}), 32'h007);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        check("t4_par_bad", 32'({p_pe, p_fe, p_data}), 32'h207);
        check("t4_pulses",  32'(vcnt1), 32'd2);

        // 6: back-to-back frames, first with tick every 4 clocks, then every clock
        repeat (64) @(negedge clk);
        v0 = vcnt0;
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        check("t6a_pulses", 32'(vcnt0 - v0), 32'd2);
        check("t6a_last",   32'({pe, fe, data}), 32'h0FF);
        tick_div = 1;
        repeat (32) @(negedge clk);
        v0 = vcnt0;
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t6b_first", 32'({pe, fe, data}), 32'h000);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        check("t6b_pulses", 32'(vcnt0 - v0), 32'd2);
        check("t6b_last",   32'({pe, fe, data}), 32'h0FF);
        repeat (32) @(negedge clk);

        check("missed_frames0", 32'(q0.size()), 32'd0);
        check("missed_frames1", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver using oversampling. It converts the asynchronous serial line `rx` into parallel words.
The bit-timing reference is an external one-cycle strobe `tick`, asserted at OVERSAMPLE × baud. It is supplied by the baud/tick generator that also drives the transmitter.
Each received frame produces a one-cycle `valid` pulse with data and error flags, for the register/FIFO layer.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
OVERSAMPLE, 16, ticks per bit period (even, >= 8)
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only if PARITY_EN = 1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle strobe at OVERSAMPLE × baud rate
rx  input  1  asynchronous serial line, idle high
data  output  DATA_BITS  last received word, held until the next frame completes
valid  output  1  one-cycle pulse: data and flags updated
parity_error  output  1  parity mismatch on the last frame, valid with `valid`, held
frame_error  output  1  stop bit sampled low on the last frame, valid with `valid`, held
busy  output  1  high in every state except IDLE

Behaviour:
- Reset and clocking:
  - One clock. Reset is asynchronous and active-high.
  - Reset drives data=0, valid=0, parity_error=0, frame_error=0, busy=0, state=IDLE, all counters 0, synchronizer flops=1.
  - Reset asserted mid-frame aborts the frame; no `valid` is emitted.
- Input synchronizer: `rx` passes through a 2-flop synchronizer to give `rx_s`, which adds 2 clock cycles of latency. The FSM uses only `rx_s`.
- Tick gating: all state, counter and shift updates happen only in cycles where tick=1. With tick=0, everything holds except the synchronizer and `valid`, which returns to 0.
- Counters:
  - `tick_cnt` is $clog2(OVERSAMPLE) bits and wraps to 0 on every state change.
  - `bit_cnt` is $clog2(DATA_BITS)+1 bits.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
  - START:
    - On a tick with tick_cnt == OVERSAMPLE/2-1 (mid start bit): if rx_s=0, go to DATA with tick_cnt=0 and bit_cnt=0.
    - If rx_s=1 instead, this is a false start: go to IDLE, no outputs change.
    - Otherwise tick_cnt++.
  - DATA:
    - On a tick with tick_cnt == OVERSAMPLE-1: shift rx_s into the MSB of the shift register (right shift, LSB first), set tick_cnt=0, bit_cnt++.
    - After the DATA_BITS-th sample, go to PARITY if PARITY_EN=1, else go to STOP.
  - PARITY: at tick_cnt == OVERSAMPLE-1, latch rx_s as the parity bit and go to STOP.
  - STOP: at tick_cnt == OVERSAMPLE-1, sample the stop bit. On the next clock edge:
    - data = shift register;
    - frame_error = !rx_s;
    - parity_error = PARITY_EN ? (^data ^ parity_bit ^ PARITY_ODD) : 0;
    - valid = 1 for exactly one cycle.
    - Then go to BREAK if rx_s=0, else go to IDLE.
  - BREAK: line held low after a bad stop bit. Stay until a tick with rx_s=1, then go to IDLE. Never start a frame from BREAK.
- Latency: `valid` rises 1 clock after the tick that samples the stop bit.
- Back-to-back frames: a start edge one tick after the stop sample is accepted. The stop bit is sampled at its middle, so IDLE is reached before the next start bit.
- Error frames still pulse `valid`. data is updated and the error flags qualify it.
- No backpressure: the consumer must take data within one frame time.

Decomposition:
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - default-parameter constants: UART_DATA_BITS=8, UART_OVERSAMPLE=16;
  - localparam helper for the mid-bit index.
- Sub-module `uart_sync`: 2-flop synchronizer with parameterized reset value (1 here), reusable by other blocks.
- FSM, counters, shift register and parity logic stay in uart_rx.

Test Plan:
- Common bench setup: defaults (8N1, OVERSAMPLE=16), tick every 4 clocks, bit period 64 clocks.
1. Send 0xA5 8N1 -> exactly one valid pulse, data=0xA5, parity_error=0, frame_error=0, busy=0 afterwards.
2. rx low for 3 ticks, then high (glitch) -> no valid pulse, busy falls at the 8th tick after detection, data unchanged.
3. Send 0x3C with stop bit 0, then hold rx low for 20 bit times, then idle, then send 0x55 -> first valid has data=0x3C and frame_error=1. No valid during the low period. Second valid has data=0x55 and frame_error=0.
4. PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 -> parity_error=0. Send 0x07 with parity bit 0 -> parity_error=1, data=0x07.
5. Send 0xFF and assert reset for 1 cycle during data bit 4 -> all outputs 0 immediately, no valid pulse. Then send 0x81 -> data=0x81, valid once.
6. Send 0x00 and 0xFF back-to-back with a single stop bit; also repeat with tick tied high every cycle -> two valid pulses, data 0x00 then 0xFF, no errors.
